// File: rtl/axi4lite_regbus_bridge.sv
// rtl/axi4lite_regbus_bridge.sv - AXI4-Lite slave to regbus master bridge
// One transaction in flight; AW/W/AR each buffered one deep, alternating read/write grant.

module axi4lite_regbus_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_SPAN      = 4096,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    reg_valid,
  output logic                    reg_write,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_wstrb,
  input  logic                    reg_ready,
  input  logic [DATA_WIDTH-1:0]   reg_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [ADDR_WIDTH:0]   SPAN  = (ADDR_WIDTH + 1)'(ADDR_SPAN);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ADDR_WIDTH'((1 << LSB) - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state_q, state_d;

  logic                  aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0] aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  prefer_read, cur_write;
  logic [1:0]            resp_code;
  logic [TW-1:0]         tcnt;

  logic                  wr_elig, rd_elig, grant_any, grant_write, grant_decerr;
  logic                  req_done, req_tout, resp_hs;
  logic [ADDR_WIDTH-1:0] grant_addr, cur_addr;

  always_comb begin
    state_d      = state_q;
    wr_elig      = aw_full & w_full;
    rd_elig      = ar_full;
    grant_any    = wr_elig | rd_elig;
    grant_write  = wr_elig & (~rd_elig | ~prefer_read);
    grant_addr   = grant_write ? aw_addr_q : ar_addr_q;
    grant_decerr = ({1'b0, grant_addr} >= SPAN);
    cur_addr     = cur_write ? aw_addr_q : ar_addr_q;
    req_done     = reg_valid & reg_ready;
    // A same-cycle reg_ready beats the timeout.
    req_tout     = (TIMEOUT_CYCLES != 0) && reg_valid && !reg_ready && (tcnt == T_LAST);
    resp_hs      = cur_write ? (bvalid & bready) : (rvalid & rready);
    case (state_q)
      IDLE:    if (grant_any) state_d = grant_decerr ? RESP : REQ;
      REQ:     if (req_done | req_tout) state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      awready     <= 1'b0;
      wready      <= 1'b0;
      arready     <= 1'b0;
      aw_full     <= 1'b0;
      w_full      <= 1'b0;
      ar_full     <= 1'b0;
      aw_addr_q   <= '0;
      ar_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      prefer_read <= 1'b1;
      cur_write   <= 1'b0;
      resp_code   <= RESP_OKAY;
      tcnt        <= '0;
      bvalid      <= 1'b0;
      bresp       <= 2'b00;
      rvalid      <= 1'b0;
      rresp       <= 2'b00;
      rdata       <= '0;
      reg_valid   <= 1'b0;
      reg_write   <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_wstrb   <= '0;
    end else begin
      // Readies follow buffer emptiness one cycle late and drop on the accepting edge.
      awready <= ~aw_full & ~(awvalid & awready);
      wready  <= ~w_full & ~(wvalid & wready);
      arready <= ~ar_full & ~(arvalid & arready);
      if (awvalid & awready) begin
        aw_full   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (wvalid & wready) begin
        w_full   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (arvalid & arready) begin
        ar_full   <= 1'b1;
        ar_addr_q <= araddr;
      end
      tcnt <= (reg_valid & ~req_done & ~req_tout) ? tcnt + 1'b1 : '0;

      case (state_q)
        IDLE: begin
          if (grant_any) begin
            cur_write   <= grant_write;
            prefer_read <= grant_write;
            if (grant_decerr) begin
              resp_code <= RESP_DECERR;
              rdata     <= '0;
            end
          end
        end
        REQ: begin
          if (!reg_valid) begin
            reg_valid <= 1'b1;
            reg_write <= cur_write;
            reg_addr  <= cur_addr & ~ALIGN;
            reg_wdata <= cur_write ? w_data_q : '0;
            reg_wstrb <= cur_write ? w_strb_q : '0;
          end else if (req_done | req_tout) begin
            reg_valid <= 1'b0;
            reg_write <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wstrb <= '0;
            resp_code <= req_done ? RESP_OKAY : RESP_SLVERR;
            rdata     <= (req_done & ~cur_write) ? reg_rdata : '0;
          end
        end
        RESP: begin
          if (cur_write) begin
            if (!bvalid) begin
              bvalid <= 1'b1;
              bresp  <= resp_code;
            end else if (bready) begin
              bvalid  <= 1'b0;
              bresp   <= 2'b00;
              aw_full <= 1'b0;
              w_full  <= 1'b0;
            end
          end else begin
            if (!rvalid) begin
              rvalid <= 1'b1;
              rresp  <= resp_code;
            end else if (rready) begin
              rvalid  <= 1'b0;
              rresp   <= 2'b00;
              rdata   <= '0;
              ar_full <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
